// File: rtl/alarm_qsys_mem_fill_check.sv
// rtl/alarm_qsys_mem_fill_check.sv - Avalon-MM fill/verify engine for the on-chip RAM s1 port.
// Optional MEMCHK_INCR_PATTERN_EN: expected word becomes pattern + index.
module alarm_qsys_mem_fill_check #(
   parameter int ADDR_W       = 11,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1,
   parameter int ERR_W        = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                verify_only,
   input  logic                abort,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     length,
   input  logic [DATA_W-1:0]   pattern,
   output logic [ADDR_W-1:0]   address,
   output logic [DATA_W/8-1:0] byteenable,
   output logic                chipselect,
   output logic                write,
   output logic [DATA_W-1:0]   writedata,
   output logic                clken,
   input  logic [DATA_W-1:0]   readdata,
   output logic                busy,
   output logic                done,
   output logic [ERR_W-1:0]    err_count,
   output logic                first_err_valid,
   output logic [ADDR_W-1:0]   first_err_addr
);
   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LATENCY - 1);

   typedef enum logic [2:0] {IDLE, FILL, VERIFY, DRAIN, DONE} state_t;
   state_t state, state_n;

   logic [ADDR_W:0]    idx, idx_n, len_q, len_in, issue_idx;
   logic [ADDR_W-1:0]  base_q, cur_base;
   logic [DATA_W-1:0]  pat_q, cur_pat, exp_n, exp_q;
   logic [DRAIN_W-1:0] drain_cnt, drain_n;
   logic               issue, issue_wr, load, busy_n, done_n, kill;
   logic               pv [READ_LATENCY];
   logic [DATA_W-1:0]  pe [READ_LATENCY];
   logic [ADDR_W-1:0]  pa [READ_LATENCY];
   logic               cmp_fire, mismatch;

   assign clken    = 1'b1;
   assign len_in   = (length > MAX_LEN) ? MAX_LEN : length;
   // In IDLE the first access is issued on the start edge, before the latches load.
   assign cur_base = (state == IDLE) ? base_addr : base_q;
   assign cur_pat  = (state == IDLE) ? pattern : pat_q;
   assign kill     = abort && (state != IDLE);

`ifdef MEMCHK_INCR_PATTERN_EN
   assign exp_n = cur_pat + DATA_W'(issue_idx);
`else
   assign exp_n = cur_pat;
`endif

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      drain_n   = drain_cnt;
      issue     = 1'b0;
      issue_wr  = 1'b0;
      issue_idx = idx;
      load      = 1'b0;
      busy_n    = busy;
      done_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !abort) begin
               load      = 1'b1;
               busy_n    = 1'b1;
               issue_idx = '0;
               idx_n     = (ADDR_W+1)'(1);
               if (len_in == '0) begin
                  state_n = DONE;
               end else begin
                  issue = 1'b1;
                  if (verify_only) begin
                     state_n = VERIFY;
                  end else begin
                     state_n  = FILL;
                     issue_wr = 1'b1;
                  end
               end
            end
         end
         FILL: begin
            issue = 1'b1;
            if (idx == len_q) begin
               state_n   = VERIFY;
               issue_idx = '0;
               idx_n     = (ADDR_W+1)'(1);
            end else begin
               issue_wr = 1'b1;
               idx_n    = idx + 1'b1;
            end
         end
         VERIFY: begin
            if (idx == len_q) begin
               state_n = DRAIN;
               drain_n = '0;
            end else begin
               issue = 1'b1;
               idx_n = idx + 1'b1;
            end
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_LAST) state_n = DONE;
            else drain_n = drain_cnt + 1'b1;
         end
         DONE: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      if (kill) begin
         state_n  = IDLE;
         issue    = 1'b0;
         issue_wr = 1'b0;
         busy_n   = 1'b0;
         done_n   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         drain_cnt  <= '0;
         len_q      <= '0;
         base_q     <= '0;
         pat_q      <= '0;
         exp_q      <= '0;
         address    <= '0;
         byteenable <= '0;
         chipselect <= 1'b0;
         write      <= 1'b0;
         writedata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         drain_cnt  <= drain_n;
         busy       <= busy_n;
         done       <= done_n;
         chipselect <= issue;
         write      <= issue_wr;
         byteenable <= issue ? '1 : '0;
         exp_q      <= exp_n;
         if (issue)    address   <= cur_base + issue_idx[ADDR_W-1:0];
         if (issue_wr) writedata <= exp_n;
         if (load) begin
            len_q  <= len_in;
            base_q <= base_addr;
            pat_q  <= pattern;
         end
      end
   end

   // Stage k holds the read issued k+1 cycles ago; the last stage lines up with readdata.
   assign cmp_fire = pv[READ_LATENCY-1] && !kill;
   assign mismatch = readdata != pe[READ_LATENCY-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < READ_LATENCY; k++) begin
            pv[k] <= 1'b0;
            pe[k] <= '0;
            pa[k] <= '0;
         end
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_addr  <= '0;
      end else begin
         pv[0] <= chipselect && !write && !kill;
         pe[0] <= exp_q;
         pa[0] <= address;
         for (int k = 1; k < READ_LATENCY; k++) begin
            pv[k] <= pv[k-1] && !kill;
            pe[k] <= pe[k-1];
            pa[k] <= pa[k-1];
         end
         if (load) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
         end else if (cmp_fire && mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_err_valid) begin
               first_err_valid <= 1'b1;
               first_err_addr  <= pa[READ_LATENCY-1];
            end
         end
      end
   end
endmodule

// File: tb/tb_alarm_qsys_mem_fill_check.sv
// tb/tb_alarm_qsys_mem_fill_check.sv - scoreboard bench with a RAM model and a word-level reference model.
module tb_alarm_qsys_mem_fill_check;
   localparam int AW = 11, DW = 32, RL = 1, EW = 16, DEPTH = 2048;

   logic          clk = 1'b0, reset = 1'b1, start = 1'b0, verify_only = 1'b0, abort = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic [DW-1:0] pattern = '0;
   logic [AW-1:0] address;
   logic [DW/8-1:0] byteenable;
   logic          chipselect, write, clken, busy, done, first_err_valid;
   logic [DW-1:0] writedata, readdata;
   logic [EW-1:0] err_count;
   logic [AW-1:0] first_err_addr;

   always #5 clk = ~clk;

   alarm_qsys_mem_fill_check #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .ERR_W(EW)) dut (
      .clk(clk), .reset(reset), .start(start), .verify_only(verify_only), .abort(abort),
      .base_addr(base_addr), .length(length), .pattern(pattern),
      .address(address), .byteenable(byteenable), .chipselect(chipselect), .write(write),
      .writedata(writedata), .clken(clken), .readdata(readdata), .busy(busy), .done(done),
      .err_count(err_count), .first_err_valid(first_err_valid), .first_err_addr(first_err_addr));

   // RAM model with a backdoor poke port
   logic [DW-1:0] mem [DEPTH];
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_addr = '0;
   logic [DW-1:0] poke_data = '0;
   always @(posedge clk) begin
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (chipselect && clken && write)
         for (int b = 0; b < DW/8; b++)
            if (byteenable[b]) mem[address][8*b +: 8] <= writedata[8*b +: 8];
      if (chipselect && clken && !write) readdata <= mem[address];
   end

   typedef struct packed {logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} acc_t;
   typedef struct packed {logic [EW-1:0] err; logic fev; logic [AW-1:0] fea; logic [31:0] cyc; logic [31:0] bcnt;} done_t;
   acc_t  acc_q[$];
   done_t dq[$];
   logic [DW-1:0] ref_mem [DEPTH];
   int checks = 0, errors = 0, cyc = 0, busy_cnt = 0;
   bit mon_en = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] p, input int i);
`ifdef MEMCHK_INCR_PATTERN_EN
      return p + DW'(i);
`else
      return p;
`endif
   endfunction

   // Monitor: compares every bus access and every done pulse against the scoreboard.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (busy) busy_cnt++;
         if (chipselect) begin
            if (acc_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_access addr=%h write=%b", address, write);
            end else begin
               acc_t e;
               e = acc_q.pop_front();
               check("access_write", 64'(write), 64'(e.wr));
               check("access_addr", 64'(address), 64'(e.addr));
               check("access_be", 64'(byteenable), 64'hF);
               if (e.wr) check("access_data", 64'(writedata), 64'(e.data));
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done err_count=%h", err_count);
            end else begin
               done_t d;
               d = dq.pop_front();
               check("done_cycle", 64'(cyc), 64'(d.cyc));
               check("busy_cycles", 64'(busy_cnt), 64'(d.bcnt));
               check("err_count", 64'(err_count), 64'(d.err));
               check("first_err_valid", 64'(first_err_valid), 64'(d.fev));
               check("first_err_addr", 64'(first_err_addr), 64'(d.fea));
            end
         end
      end
   end

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic run_op(input logic [AW-1:0] b, input int len_raw, input logic [DW-1:0] p,
                         input logic vo, input int abort_cyc, input bit skip_sync);
      acc_t seq[$];
      done_t d;
      int n, lim, k_done, cs, errs, k;
      logic fev;
      logic [AW-1:0] fea, ra;
      n = (len_raw > DEPTH) ? DEPTH : len_raw;
      if (!vo) for (int i = 0; i < n; i++) seq.push_back({1'b1, AW'(b + i), exp_word(p, i)});
      for (int i = 0; i < n; i++) seq.push_back({1'b0, AW'(b + i), {DW{1'b0}}});
      lim = (abort_cyc >= 0 && abort_cyc + 1 < seq.size()) ? abort_cyc + 1 : seq.size();
      for (int i = 0; i < lim; i++) begin
         acc_q.push_back(seq[i]);
         if (seq[i].wr) ref_mem[seq[i].addr] = seq[i].data;
      end
      errs = 0; fev = 1'b0; fea = '0;
      for (int i = 0; i < n; i++) begin
         ra = AW'(b + i);
         if (ref_mem[ra] != exp_word(p, i)) begin
            if (errs < (1 << EW) - 1) errs++;
            if (!fev) begin fev = 1'b1; fea = ra; end
         end
      end
      k_done = (n == 0) ? 1 : (vo ? n + RL + 1 : 2 * n + RL + 1);
      if (!skip_sync) @(negedge clk);
      cs = cyc;
      if (abort_cyc < 0) begin
         d = '{err: EW'(errs), fev: fev, fea: fea, cyc: 32'(cs + 1 + k_done), bcnt: 32'(k_done)};
         dq.push_back(d);
      end
      base_addr = b; length = (AW+1)'(len_raw); pattern = p; verify_only = vo; start = 1'b1;
      busy_cnt = 0;
      @(negedge clk);
      start = 1'b0;
      base_addr = AW'($urandom); pattern = $urandom; length = (AW+1)'($urandom); verify_only = 1'($urandom);
      if (abort_cyc >= 0) begin
         repeat (abort_cyc) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         check("abort_chipselect", 64'(chipselect), 64'd0);
         check("abort_busy", 64'(busy), 64'd0);
         check("abort_err_hold", 64'(err_count), 64'd0);
      end else begin
         k = 0;
         while (!done && k < 10000) begin
            @(negedge clk);
            k++;
         end
         if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout waited=%0d required=%0d", k, k_done);
         end
         @(negedge clk);
         check("queues_drained", 64'(acc_q.size() + dq.size()), 64'd0);
         acc_q.delete(); dq.delete();
      end
   endtask

   initial begin
      logic [DW-1:0] last_pat;
      int k;
      repeat (3) @(negedge clk);
      check("reset_outputs", {address, byteenable, chipselect, write, busy, done, first_err_valid}, 64'd0);
      check("reset_status", {err_count, first_err_addr, writedata[15:0]}, 64'd0);
      check("clken_tied", 64'(clken), 64'd1);
      reset = 1'b0;

      run_op(11'h000, 4095, 32'h0, 1'b0, -1, 1'b0);                 // clamped full-memory fill
      run_op(11'h010, 4, 32'hA5A5A5A5, 1'b0, -1, 1'b0);
      run_op(11'h7FE, 4, 32'h12345678, 1'b0, -1, 1'b0);             // wraps 0x7FF -> 0x000
      for (int i = 0; i < 8; i++) poke(AW'(i), 32'h0);
      poke(11'h005, 32'h1);
      run_op(11'h000, 8, 32'h0, 1'b1, -1, 1'b0);
      run_op(11'h123, 0, 32'hDEADBEEF, 1'b0, -1, 1'b0);
      run_op(11'h200, 100, $urandom, 1'b0, 2, 1'b0);
      run_op(11'h240, 5, 32'h0F0F0F0F, 1'b0, -1, 1'b1);             // start right after abort
      run_op(11'h300, 3, 32'hFFFFFFFE, 1'b0, -1, 1'b0);

      // asynchronous reset in the middle of VERIFY
      mon_en = 1'b0;
      for (int i = 0; i < 3; i++) ref_mem[AW'(11'h300 + i)] = exp_word(32'hFFFFFFFE, i);
      @(negedge clk);
      base_addr = 11'h300; length = 12'd3; pattern = 32'hFFFFFFFE; verify_only = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!(chipselect && !write) && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("reached_verify", 64'(chipselect && !write), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_outputs", {address, byteenable, chipselect, write, busy, done, first_err_valid}, 64'd0);
      check("async_reset_status", {err_count, first_err_addr, writedata[15:0]}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      mon_en = 1'b1;

      last_pat = 32'h0F0F0F0F;
      for (int t = 0; t < 25; t++) begin
         logic [DW-1:0] p;
         logic vo;
         int len;
         vo  = 1'($urandom);
         len = $urandom_range(0, 40);
         p   = ($urandom_range(0, 1) == 1) ? last_pat : $urandom;
         if (vo && len > 0) poke(AW'(11'h240 + $urandom_range(0, 4)), $urandom);
         run_op(vo ? 11'h240 : AW'($urandom), len, p, vo, -1, 1'b0);
         if (!vo) last_pat = p;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
